ds1302_time_writer: RTL and testbench
=====================================

DS1302_TIME_WRITER -- requirements
Module: ds1302_time_writer

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst, sampled on the rising edge of clk.
REQ-002 Parameter CLK_DIV SHALL default to 50 and set the number of clk cycles per SCLK half-period (legal values 2..1023).
REQ-003 Port clk SHALL be an input, 1 bit: system clock, rising-edge active.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-005 Port start SHALL be an input, 1 bit: a one-cycle pulse that requests a time write.
REQ-006 Port hr SHALL be an input, 5 bits: binary hour, 0..23.
REQ-007 Port min SHALL be an input, 6 bits: binary minute, 0..59.
REQ-008 Port sec SHALL be an input, 6 bits: binary second, 0..59.
REQ-009 Port busy SHALL be an output, 1 bit: high while a write sequence is in progress.
REQ-010 Port done SHALL be an output, 1 bit: a one-cycle pulse when the sequence completes.
REQ-011 Port ds_ce SHALL be an output, 1 bit: DS1302 chip enable.
REQ-012 Port ds_sclk SHALL be an output, 1 bit: DS1302 serial clock.
REQ-013 Port ds_io SHALL be an output, 1 bit: DS1302 serial data.
REQ-014 Port ds_io_oe SHALL be an output, 1 bit: tristate enable for the I/O pad, high while a transaction is active.

Function
REQ-015 A start pulse in IDLE SHALL latch hr, min and sec; start SHALL be ignored while busy=1.
REQ-016 Latched values above range SHALL clamp: hr>23 becomes 23; min>59 or sec>59 becomes 59.
REQ-017 Binary-to-BCD conversion: tens = value/10, ones = value%10. Data bytes: sec={0,tens[2:0],ones} (CH=0); min={0,tens[2:0],ones}; hr={0,0,tens[1:0],ones} (bit7=0 selects 24-hour mode).
REQ-018 The transaction order SHALL be [WP clear: cmd 0x8E, data 0x00], then sec (cmd 0x80), then min (cmd 0x82), then hr (cmd 0x84).
REQ-019 The FSM SHALL have the states IDLE, CE_SETUP, SHIFT, CE_HOLD, GAP and DONE.
REQ-020 Each transaction SHALL run CE_SETUP (ce=1, sclk=0, CLK_DIV cycles), then SHIFT, then CE_HOLD (ce=1, sclk=0, CLK_DIV cycles), then GAP (ce=0, 2*CLK_DIV cycles), for a total of 36*CLK_DIV cycles.
REQ-021 SHIFT SHALL send 16 bits, LSB first: command byte, then data byte.
REQ-022 Each SHIFT bit SHALL drive ds_io at the start of an sclk-low half of CLK_DIV cycles, followed by an sclk-high half of CLK_DIV cycles; ds_io SHALL be stable throughout the high half.
REQ-023 After the GAP of the last transaction the FSM SHALL enter DONE for exactly one cycle (done=1, busy=0), then return to IDLE.
REQ-024 busy SHALL rise in the cycle after the accepted start and stay high through the last GAP cycle.
REQ-025 A start pulse coincident with DONE SHALL be ignored; a start pulse in the first IDLE cycle after DONE SHALL be accepted.
REQ-026 ds_io_oe SHALL equal ds_ce; ds_io SHALL be 0 whenever ds_ce=0.
REQ-027 Bit and byte counters SHALL never wrap inside a transaction: the transaction ends exactly after bit 15.

Reset
REQ-028 While rst=1, outputs SHALL be ds_ce=0, ds_sclk=0, ds_io=0, ds_io_oe=0, busy=0 and done=0; the state SHALL be IDLE and the latched time 0.
REQ-029 rst asserted mid-transaction SHALL abort the sequence: ds_ce falls on the next clk edge, and no done pulse is generated.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-031 With macro DS1302_WP_CLEAR_EN defined, the write-protect-clear transaction SHALL precede sec/min/hr (4 transactions, 144*CLK_DIV cycles from start to done).
REQ-032 Without DS1302_WP_CLEAR_EN, only the sec, min and hr transactions SHALL occur (108*CLK_DIV cycles).

Verification (CLK_DIV=2)
REQ-033 Scenario: hr=13, min=45, sec=7, WP enabled, start pulse -> serial bytes 8E/00, 80/07, 82/45, 84/13 (LSB first); done pulses 288 cycles after start.
REQ-034 Scenario: hr=31, min=63, sec=60 -> clamped bytes sec=0x59, min=0x59, hr=0x23.
REQ-035 Scenario: second start pulse during the sec transaction -> ignored; exactly one done pulse; byte stream unchanged.
REQ-036 Scenario: rst raised at bit 5 of the min transaction -> ds_ce=0 next cycle, busy=0, no done; a later start runs a full sequence.
REQ-037 Scenario: WP macro undefined, hr=0, min=0, sec=0 -> three transactions 80/00, 82/00, 84/00; done 216 cycles after start.
REQ-038 Scenario: check the protocol monitor -> ds_io never changes while ds_sclk=1; ds_ce low for ≥4 cycles between transactions.

Source files
------------

// File: rtl/ds1302_time_writer.sv
`default_nettype none
// ============================================================================
// Module   : ds1302_time_writer
// Brief    : Writes hour/minute/second (24-hour, BCD) into a DS1302 RTC over
//            its 3-wire serial interface. Each register write is one CE-framed
//            transaction of 16 bits (command byte, then data byte, LSB first).
//            Inputs are clamped to range and converted to BCD before sending.
// Config   : define DS1302_WP_CLEAR_EN to prepend a write-protect-clear
//            transaction (cmd 0x8E, data 0x00) before the time registers.
// Revision : 1.0 - initial release
// ============================================================================
module ds1302_time_writer #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       busy,
    output logic       done,
    output logic       ds_ce,
    output logic       ds_sclk,
    output logic       ds_io,
    output logic       ds_io_oe
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CE_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT    = 3'd2;
    localparam logic [2:0] c_CE_HOLD  = 3'd3;
    localparam logic [2:0] c_GAP      = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    // Divider terminal counts: one SCLK half-period, and the CE-low gap
    localparam logic [10:0] c_HALF_LAST = 11'(CLK_DIV - 1);
    localparam logic [10:0] c_GAP_LAST  = 11'(2 * CLK_DIV - 1);

    // Transaction index 0 is the write-protect clear; 1..3 are sec/min/hr
`ifdef DS1302_WP_CLEAR_EN
    localparam logic [1:0] c_FIRST_TXN = 2'd0;
`else
    localparam logic [1:0] c_FIRST_TXN = 2'd1;
`endif
    localparam logic [1:0] c_LAST_TXN  = 2'd3;

    logic [2:0]  r_state;
    logic [10:0] r_div;
    logic [3:0]  r_bit;
    logic        r_phase;      // 0: sclk-low half, 1: sclk-high half
    logic [1:0]  r_txn;
    logic [15:0] r_shift;      // {data, cmd}; bit 0 is on the wire
    logic [4:0]  r_hr;
    logic [5:0]  r_min;
    logic [5:0]  r_sec;

    logic [2:0]  w_sec_tens;
    logic [3:0]  w_sec_ones;
    logic [2:0]  w_min_tens;
    logic [3:0]  w_min_ones;
    logic [1:0]  w_hr_tens;
    logic [3:0]  w_hr_ones;
    logic [7:0]  w_cmd;
    logic [7:0]  w_data;
    logic        w_half_end;

    // Latched values are already clamped, so the tens digits fit their fields
    assign w_sec_tens = 3'(r_sec / 6'd10);
    assign w_sec_ones = 4'(r_sec % 6'd10);
    assign w_min_tens = 3'(r_min / 6'd10);
    assign w_min_ones = 4'(r_min % 6'd10);
    assign w_hr_tens  = 2'(r_hr / 5'd10);
    assign w_hr_ones  = 4'(r_hr % 5'd10);

    assign w_half_end = (r_div == c_HALF_LAST);

    // Command/data byte for the current transaction (CH=0, 24-hour mode)
    always_comb begin
        w_cmd  = 8'h8E;
        w_data = 8'h00;
        case (r_txn)
            2'd1: begin
                w_cmd  = 8'h80;
                w_data = {1'b0, w_sec_tens, w_sec_ones};
            end
            2'd2: begin
                w_cmd  = 8'h82;
                w_data = {1'b0, w_min_tens, w_min_ones};
            end
            2'd3: begin
                w_cmd  = 8'h84;
                w_data = {2'b00, w_hr_tens, w_hr_ones};
            end
            default: begin
                w_cmd  = 8'h8E;
                w_data = 8'h00;
            end
        endcase
    end

    // Sequencer: frames each transaction and shifts its 16 bits out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_txn   <= c_FIRST_TXN;
            r_shift <= '0;
            r_hr    <= '0;
            r_min   <= '0;
            r_sec   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_hr    <= (hr  > 5'd23) ? 5'd23 : hr;
                        r_min   <= (min > 6'd59) ? 6'd59 : min;
                        r_sec   <= (sec > 6'd59) ? 6'd59 : sec;
                        r_txn   <= c_FIRST_TXN;
                        r_div   <= '0;
                        r_state <= c_CE_SETUP;
                    end
                end
                c_CE_SETUP: begin
                    if (w_half_end) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                        r_shift <= {w_data, w_cmd};
                        r_state <= c_SHIFT;
                    end else begin
                        r_div <= r_div + 11'd1;
                    end
                end
                c_SHIFT: begin
                    if (w_half_end) begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            // Stop after bit 15 rather than letting r_bit wrap
                            if (r_bit == 4'd15) begin
                                r_state <= c_CE_HOLD;
                            end else begin
                                r_bit   <= r_bit + 4'd1;
                                r_shift <= {1'b0, r_shift[15:1]};
                            end
                        end
                    end else begin
                        r_div <= r_div + 11'd1;
                    end
                end
                c_CE_HOLD: begin
                    if (w_half_end) begin
                        r_div   <= '0;
                        r_state <= c_GAP;
                    end else begin
                        r_div <= r_div + 11'd1;
                    end
                end
                c_GAP: begin
                    if (r_div == c_GAP_LAST) begin
                        r_div <= '0;
                        if (r_txn == c_LAST_TXN) begin
                            r_state <= c_DONE;
                        end else begin
                            r_txn   <= r_txn + 2'd1;
                            r_state <= c_CE_SETUP;
                        end
                    end else begin
                        r_div <= r_div + 11'd1;
                    end
                end
                c_DONE: begin
                    // start is deliberately not sampled here
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state, so reset clears them
    // on the same edge that returns the FSM to IDLE
    assign busy     = (r_state == c_CE_SETUP) || (r_state == c_SHIFT) ||
                      (r_state == c_CE_HOLD)  || (r_state == c_GAP);
    assign done     = (r_state == c_DONE);
    assign ds_ce    = (r_state == c_CE_SETUP) || (r_state == c_SHIFT) ||
                      (r_state == c_CE_HOLD);
    assign ds_sclk  = (r_state == c_SHIFT) && r_phase;
    assign ds_io    = (r_state == c_SHIFT) && r_shift[0];
    assign ds_io_oe = ds_ce;

endmodule
`default_nettype wire

// File: tb/tb_ds1302_time_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds1302_time_writer
// Brief    : Directed self-checking bench for ds1302_time_writer (CLK_DIV=2).
//            A serial monitor reassembles each CE-framed 16-bit word and
//            tracks wire-level protocol rules; scenario tasks compare against
//            hand-computed BCD words and cycle counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds1302_time_writer;

    localparam int CLK_DIV = 2;
`ifdef DS1302_WP_CLEAR_EN
    localparam int NTXN = 4;
`else
    localparam int NTXN = 3;
`endif
    localparam int SEQ_CYC = 36 * CLK_DIV * NTXN;
    localparam int TXN_CYC = 36 * CLK_DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [4:0] hr    = '0;
    logic [5:0] min   = '0;
    logic [5:0] sec   = '0;
    logic       busy;
    logic       done;
    logic       ds_ce;
    logic       ds_sclk;
    logic       ds_io;
    logic       ds_io_oe;

    int n_tests = 0;
    int n_fail  = 0;

    ds1302_time_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hr       (hr),
        .min      (min),
        .sec      (sec),
        .busy     (busy),
        .done     (done),
        .ds_ce    (ds_ce),
        .ds_sclk  (ds_sclk),
        .ds_io    (ds_io),
        .ds_io_oe (ds_io_oe)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Serial monitor: captures bits on sclk rise, pushes a word on ce fall
    // ------------------------------------------------------------------------
    logic [15:0] mon_word   = '0;
    int          mon_bits   = 0;
    logic [15:0] mon_q[$];
    int          mon_bq[$];
    logic        prev_ce    = 1'b0;
    logic        prev_sclk  = 1'b0;
    logic        prev_io    = 1'b0;
    int          ce_low_run = 1000;
    int          min_gap    = 1000;
    int          proto_err  = 0;

    always @(negedge clk) begin
        if ((ds_sclk && (ds_io !== prev_io)) ||
            (!ds_ce && (ds_io !== 1'b0)) ||
            (ds_io_oe !== ds_ce))
            proto_err <= proto_err + 1;
        if (ds_ce && !prev_ce) begin
            if (ce_low_run < min_gap) min_gap <= ce_low_run;
            mon_word <= '0;
            mon_bits <= 0;
        end else if (ds_sclk && !prev_sclk) begin
            mon_word <= {ds_io, mon_word[15:1]};
            mon_bits <= mon_bits + 1;
        end
        if (!ds_ce && prev_ce) begin
            mon_q.push_back(mon_word);
            mon_bq.push_back(mon_bits);
        end
        ce_low_run <= ds_ce ? 0 : ce_low_run + 1;
        prev_ce    <= ds_ce;
        prev_sclk  <= ds_sclk;
        prev_io    <= ds_io;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic pulse_start(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        hr = h; min = m; sec = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge just after the edge that accepted start
    task automatic start_seq(input string name, input logic [4:0] h,
                             input logic [5:0] m, input logic [5:0] s);
        mon_q.delete();
        mon_bq.delete();
        pulse_start(h, m, s);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_rise: got %b expected 1", name, busy);
        end
    endtask

    // Waits for done (cycles counted from the accepting edge, cyc0 already
    // elapsed), then checks latency, busy and the captured byte stream.
    // Returns on the negedge where done is high.
    task automatic finish_seq(input string name, input int cyc0,
                              input logic [15:0] e_sec, input logic [15:0] e_min,
                              input logic [15:0] e_hr);
        logic [15:0] exp_w[4];
        int          cyc;
        exp_w[0] = 16'h008E;
        exp_w[1] = e_sec;
        exp_w[2] = e_min;
        exp_w[3] = e_hr;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < SEQ_CYC + 50) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc != SEQ_CYC) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d cycles expected %0d", name, cyc, SEQ_CYC);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
        end
        n_tests++;
        if (mon_q.size() != NTXN) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", name, mon_q.size(), NTXN);
        end else begin
            for (int i = 0; i < NTXN; i++) begin
                n_tests++;
                if (mon_q[i] !== exp_w[i + 4 - NTXN] || mon_bq[i] != 16) begin
                    n_fail++;
                    $display("FAIL %s word%0d: got %h (%0d bits) expected %h (16 bits)",
                             name, i, mon_q[i], mon_bq[i], exp_w[i + 4 - NTXN]);
                end
            end
        end
    endtask

    task automatic check_done_cleared(input string name);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: got %b expected 0", name, done);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        hr = 5'd13; min = 6'd45; sec = 6'd7; start = 1'b1;   // start during rst
        @(negedge clk);
        n_tests++;
        if ({ds_ce, ds_sclk, ds_io, ds_io_oe, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ce=%b sclk=%b io=%b oe=%b busy=%b done=%b expected all 0",
                     ds_ce, ds_sclk, ds_io, ds_io_oe, busy, done);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || ds_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: got busy=%b ce=%b expected 0/0", busy, ds_ce);
        end
    endtask

    task automatic test_nominal;
        start_seq("nominal", 5'd13, 6'd45, 6'd7);
        finish_seq("nominal", 0, 16'h0780, 16'h4582, 16'h1384);
        check_done_cleared("nominal");
    endtask

    task automatic test_clamp;
        start_seq("clamp", 5'd31, 6'd63, 6'd60);
        finish_seq("clamp", 0, 16'h5980, 16'h5982, 16'h2384);
        check_done_cleared("clamp");
    endtask

    task automatic test_zero;
        start_seq("zero", 5'd0, 6'd0, 6'd0);
        finish_seq("zero", 0, 16'h0080, 16'h0082, 16'h0084);
        check_done_cleared("zero");
    endtask

    // Second start lands inside the sec transaction and must be ignored
    task automatic test_back_to_back;
        int k;
        int done_cnt;
        k = (NTXN - 3) * TXN_CYC + 20;
        start_seq("b2b", 5'd9, 6'd10, 6'd30);
        repeat (k) @(negedge clk);
        pulse_start(5'd1, 6'd2, 6'd3);
        finish_seq("b2b", k + 2, 16'h3080, 16'h1082, 16'h0984);
        done_cnt = 0;
        repeat (SEQ_CYC + 10) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        n_tests++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_extra_activity: got %0d busy/done cycles expected 0", done_cnt);
        end
    endtask

    // Start held across DONE is ignored; held into first IDLE cycle is taken
    task automatic test_start_at_done;
        start_seq("at_done", 5'd13, 6'd45, 6'd7);
        finish_seq("at_done", 0, 16'h0780, 16'h4582, 16'h1384);
        hr = 5'd1; min = 6'd2; sec = 6'd3; start = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL at_done_ignored: got busy=%b done=%b expected 0/0", busy, done);
        end
        hr = 5'd22; min = 6'd8; sec = 6'd59;
        mon_q.delete();
        mon_bq.delete();
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL after_done_accepted: got busy=%b expected 1", busy);
        end
        finish_seq("after_done", 0, 16'h5980, 16'h0882, 16'h2284);
        check_done_cleared("after_done");
    endtask

    // Reset during bit 5 of the min transaction aborts with no done
    task automatic test_abort;
        int cyc;
        int done_cnt;
        start_seq("abort", 5'd13, 6'd45, 6'd7);
        cyc = 0;
        while (!(mon_q.size() == NTXN - 2 && mon_bits == 6) && cyc < SEQ_CYC) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc >= SEQ_CYC) begin
            n_fail++;
            $display("FAIL abort_reach_bit5: got timeout after %0d cycles expected min bit 5", cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ds_ce !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ce=%b busy=%b expected 0/0", ds_ce, busy);
        end
        rst = 1'b0;
        done_cnt = 0;
        repeat (SEQ_CYC + 10) begin
            @(negedge clk);
            if (done === 1'b1 || ds_ce === 1'b1) done_cnt++;
        end
        n_tests++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done/ce cycles expected 0", done_cnt);
        end
        start_seq("restart", 5'd23, 6'd59, 6'd59);
        finish_seq("restart", 0, 16'h5980, 16'h5982, 16'h2384);
        check_done_cleared("restart");
    endtask

    task automatic test_protocol;
        n_tests++;
        if (proto_err != 0) begin
            n_fail++;
            $display("FAIL protocol_rules: got %0d violations expected 0", proto_err);
        end
        n_tests++;
        if (min_gap < 2 * CLK_DIV || min_gap >= 1000) begin
            n_fail++;
            $display("FAIL ce_gap: got %0d cycles expected >= %0d", min_gap, 2 * CLK_DIV);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_clamp;
        test_zero;
        test_back_to_back;
        test_start_at_done;
        test_abort;
        test_protocol;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
